// File: rtl/tile_data_mem.sv
// tile_data_mem: tile data memory responder with clear-on-reset sweep, in-order load queue and write-first forwarding
module tile_data_mem #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int REG_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [REG_W-1:0]  rd_reg,
  output logic              rd_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [REG_W-1:0]  resp_reg,
  input  logic              resp_ready,
  output logic              init_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [REG_W-1:0]  q_reg  [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;
  logic              wr_en, push, pop;
  always_comb state_nx = (state == CLEAR && &clr_cnt) ? RUN : state;
  assign init_done = state == RUN;
  assign rd_ready  = init_done && cnt < CW'(FIFO_DEPTH);
  assign wr_en     = init_done && wr_valid;
  assign push      = rd_valid && rd_ready;
  assign pop       = cnt != '0 && (!resp_valid || resp_ready);
  always_ff @(posedge clk)
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  // Stores arriving during the sweep are dropped; the sweep owns the write port.
  always_ff @(posedge clk)
    if (rst) begin
      if (state == CLEAR) mem[clr_cnt] <= '0;
      else if (wr_valid) mem[wr_addr] <= wr_data;
    end
  always_ff @(posedge clk)
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        q_addr[wp] <= rd_addr;
        q_reg[wp]  <= rd_reg;
        wp         <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  // A store landing on the popped address at the same edge wins over the array contents.
  always_ff @(posedge clk)
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_reg   <= '0;
    end else if (pop) begin
      resp_valid <= 1'b1;
      resp_data  <= (wr_en && wr_addr == q_addr[rp]) ? wr_data : mem[q_addr[rp]];
      resp_reg   <= q_reg[rp];
    end else if (resp_ready) resp_valid <= 1'b0;
endmodule

// File: tb/tb_tile_data_mem.sv
// tb_tile_data_mem: vector table, directed corner sequences and a randomized run against a queue-based model
module tb_tile_data_mem;
  logic        clk = 0, rst = 0;
  logic        wr_valid = 0, rd_valid = 0, resp_ready = 0;
  logic [9:0]  wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic [2:0]  rd_reg = 0;
  logic        rd_ready, resp_valid, init_done;
  logic [31:0] resp_data;
  logic [2:0]  resp_reg;
  int passed = 0, total = 0;

  tile_data_mem dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_reg(rd_reg), .rd_ready(rd_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_reg(resp_reg),
    .resp_ready(resp_ready), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {logic [9:0] addr; logic [31:0] data; logic [2:0] rg; logic [31:0] exp_d;} vec_t;
  typedef struct {logic [9:0] a; logic [2:0] r; logic [31:0] d;} ld_t;
  vec_t tv[6];
  ld_t  q[$];
  logic [31:0] mm[16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic store(input logic [9:0] a, input logic [31:0] d);
    wr_valid = 1; wr_addr = a; wr_data = d;
    tick;
    wr_valid = 0;
  endtask

  task automatic do_load(input logic [9:0] a, input logic [2:0] r, input logic [31:0] exp_d, input string nm);
    int n = 0;
    resp_ready = 1;
    while (!rd_ready && n < 50) begin tick; n++; end
    rd_valid = 1; rd_addr = a; rd_reg = r;
    tick;
    rd_valid = 0;
    n = 1;
    while (!resp_valid && n < 20) begin tick; n++; end
    check({nm, " latency"}, n, 2);
    check({nm, " data"}, resp_data, exp_d);
    check({nm, " reg"}, {29'd0, resp_reg}, {29'd0, r});
  endtask

  task automatic wait_init(output int n, output int bad_ready, output int bad_resp, input int wr_at);
    n = 0; bad_ready = 0; bad_resp = 0;
    while (!init_done && n < 2000) begin
      if (rd_ready) bad_ready++;
      if (resp_valid) bad_resp++;
      if (n == wr_at) begin wr_valid = 1; wr_addr = 2; wr_data = 32'hAA; end
      tick;
      wr_valid = 0;
      n++;
    end
  endtask

  initial begin
    int n, br, bv, acc;
    logic [9:0] wa;
    bit hit;
    tv[0] = '{10'h3FF, 32'hDEADBEEF, 3'd3, 32'hDEADBEEF};
    tv[1] = '{10'h000, 32'h00000001, 3'd0, 32'h00000001};
    tv[2] = '{10'h200, 32'hA5A5A5A5, 3'd7, 32'hA5A5A5A5};
    tv[3] = '{10'h155, 32'hFFFFFFFF, 3'd5, 32'hFFFFFFFF};
    tv[4] = '{10'h2AA, 32'h12345678, 3'd1, 32'h12345678};
    tv[5] = '{10'h001, 32'h80000000, 3'd6, 32'h80000000};

    rst = 0;
    tick; tick;
    check("reset resp_valid", {31'd0, resp_valid}, 0);
    check("reset resp_data", resp_data, 0);
    check("reset init_done", {31'd0, init_done}, 0);
    check("reset rd_ready", {31'd0, rd_ready}, 0);
    rst = 1;
    wait_init(n, br, bv, -1);
    check("clear cycles", n, 1024);
    check("rd_ready during clear", br, 0);
    check("init_done after clear", {31'd0, init_done}, 1);
    do_load(10'd5, 3'd2, 32'd0, "cleared addr 5");

    foreach (tv[i]) begin
      store(tv[i].addr, tv[i].data);
      do_load(tv[i].addr, tv[i].rg, tv[i].exp_d, $sformatf("vec%0d", i));
    end

    tick;
    rd_valid = 1; rd_addr = 7; rd_reg = 4;
    tick;
    rd_valid = 0;
    store(10'd7, 32'h1234);
    check("fwd valid", {31'd0, resp_valid}, 1);
    check("fwd data", resp_data, 32'h1234);
    tick;

    wr_valid = 1; wr_addr = 9; wr_data = 32'h99;
    rd_valid = 1; rd_addr = 9; rd_reg = 2;
    tick;
    wr_valid = 0; rd_valid = 0;
    tick;
    check("same-cycle store seen", resp_data, 32'h99);
    tick;

    for (int i = 0; i < 6; i++) store(10'(i), 32'h100 + i);
    resp_ready = 0; acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (acc < 6) begin rd_valid = 1; rd_addr = 10'(acc); rd_reg = 3'(acc); end
      else rd_valid = 0;
      if (rd_valid && rd_ready) acc++;
      tick;
    end
    rd_valid = 0;
    check("bp accepted", acc, 5);
    check("bp rd_ready low", {31'd0, rd_ready}, 0);
    check("bp held data", resp_data, 32'h100);
    check("bp held reg", {29'd0, resp_reg}, 0);
    resp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp resp%0d", i), {resp_valid, 28'd0, resp_reg}, {1'b1, 28'd0, 3'(i)});
      check($sformatf("bp data%0d", i), resp_data, 32'h100 + i);
      tick;
    end
    check("bp drained", {31'd0, resp_valid}, 0);

    foreach (mm[i]) mm[i] = 0;
    for (int c = 0; c < 800; c++) begin
      resp_ready = ($urandom % 4) != 0;
      rd_valid = (c < 700) && ($urandom % 2);
      rd_addr = 10'h380 + 10'($urandom % 16);
      rd_reg = 3'($urandom);
      wa = 10'h380 + 10'($urandom % 16);
      hit = 0;
      foreach (q[k]) if (q[k].a == wa) hit = 1;
      wr_valid = !hit && ($urandom % 2);
      wr_addr = wa; wr_data = $urandom;
      if (resp_valid) begin
        if (q.size() == 0) check("rand stale resp", 1, 0);
        else begin
          check("rand data", resp_data, q[0].d);
          check("rand reg", {29'd0, resp_reg}, {29'd0, q[0].r});
          if (resp_ready) void'(q.pop_front());
        end
      end
      if (wr_valid) mm[wa[3:0]] = wr_data;
      if (rd_valid && rd_ready) q.push_back('{rd_addr, rd_reg, mm[rd_addr[3:0]]});
      tick;
    end
    wr_valid = 0; rd_valid = 0;
    check("rand queue drained", q.size(), 0);
    check("rand no trailing resp", {31'd0, resp_valid}, 0);

    resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1; rd_addr = 10'h3FF; rd_reg = 3'(i);
      tick;
    end
    rd_valid = 0;
    rst = 0;
    tick;
    rst = 1;
    resp_ready = 1;
    check("midreset resp_valid", {31'd0, resp_valid}, 0);
    check("midreset init_done", {31'd0, init_done}, 0);
    wait_init(n, br, bv, 10);
    check("reclear cycles", n, 1024);
    check("reclear stale resp", bv, 0);
    check("reclear rd_ready", br, 0);
    for (int c = 0; c < 3; c++) begin
      if (resp_valid) check("post-reset stale resp", 1, 0);
      tick;
    end
    do_load(10'd2, 3'd1, 32'd0, "store during clear dropped");
    do_load(10'h3FF, 3'd3, 32'd0, "recleared 0x3FF");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
